// File: rtl/tdm_demux_if.sv
// Serial TDM receive link: bit stream in, framed parallel words and status out.
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    logic                din;
    logic                din_valid;
    logic                sync;
    logic [N_CH*W-1:0]   dout;
    logic                frame_valid;
    logic                sync_err;
    logic                busy;

    modport master (
        output din, din_valid, sync,
        input  dout, frame_valid, sync_err, busy
    );

    modport slave (
        input  din, din_valid, sync,
        output dout, frame_valid, sync_err, busy
    );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: hunts for sync, shifts N_CH words of W bits MSB-first,
// and presents each complete frame in parallel with a one-cycle strobe.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);
    localparam int FW = N_CH * W;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [0:0] S_HUNT = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);

    logic [0:0]    r_state;
    logic [BW-1:0] r_bit_cnt;
    logic [CW-1:0] r_ch_cnt;
    logic [FW-1:0] r_shift;
    logic [FW-1:0] r_dout;
    logic          r_frame_valid;
    logic          r_sync_err;

    logic          w_last;
    logic [FW-1:0] w_shift_next;
    logic [FW-1:0] w_shift_load;

    assign w_last       = (r_bit_cnt == LAST_BIT) && (r_ch_cnt == LAST_CH);
    assign w_shift_next = {r_shift[FW-2:0], bus.din};
    assign w_shift_load = {{(FW-1){1'b0}}, bus.din};

    // NOTE: all state here is registered with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_HUNT;
            r_bit_cnt     <= '0;
            r_ch_cnt      <= '0;
            r_shift       <= '0;
            r_dout        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.din_valid) begin
                if (bus.sync) begin
                    // A sync always restarts at bit 0 of channel 0; mid-frame it is an error.
                    r_sync_err <= (r_state == S_RECV);
                    r_shift    <= w_shift_load;
                    r_bit_cnt  <= BW'(1);
                    r_ch_cnt   <= '0;
                    r_state    <= S_RECV;
                end else if (r_state == S_RECV) begin
                    r_shift <= w_shift_next;
                    if (w_last) begin
                        r_dout        <= w_shift_next;
                        r_frame_valid <= 1'b1;
                        r_bit_cnt     <= '0;
                        r_ch_cnt      <= '0;
                        r_state       <= S_HUNT;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_ch_cnt  <= r_ch_cnt + CW'(1);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sync_err    = r_sync_err;
    assign bus.busy        = (r_state == S_RECV);
endmodule
